bidir_line_ctrl: RTL and testbench

- Half-duplex serial link controller. It sits directly upstream of one bidirectional tristate buffer on a shared single-wire line.
- It generates the buffer's drive enable and drive value, and consumes the buffer's sampled line value.
- It serialises host words onto the line, and guarantees turnaround guard gaps so that two ends never drive the line at once.
- It optionally waits for and deserialises a reply from the peer.
- The line has an external pull-up, so the released/idle level is 1.

---
 rtl/bidir_line_ctrl_if.sv | 32 +++
 rtl/bidir_line_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_bidir_line_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bidir_line_ctrl_if.sv
// Host-side interface of the half-duplex line controller.
//   master : host side (drives tx_valid/tx_data/expect_reply, observes status/replies)
//   slave  : controller side
// Signals:
//   tx_valid, tx_data, expect_reply : word offered by the host
//   tx_ready                        : controller accepts a word this cycle
//   rx_valid, rx_data               : received word and its one-cycle strobe
//   rx_err, rx_timeout              : one-cycle error / no-reply strobes
//   busy                            : controller not idle
interface bidir_line_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  expect_reply;
    logic                  tx_ready;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_err;
    logic                  rx_timeout;
    logic                  busy;

    modport master (
        output tx_valid, tx_data, expect_reply,
        input  tx_ready, rx_valid, rx_data, rx_err, rx_timeout, busy
    );

    modport slave (
        input  tx_valid, tx_data, expect_reply,
        output tx_ready, rx_valid, rx_data, rx_err, rx_timeout, busy
    );
endinterface

// File: rtl/bidir_line_ctrl.sv
// Half-duplex single-wire link controller sitting in front of one tristate buffer.
// Serialises host words (start 0, data MSB first, stop 1), keeps guard gaps around every
// drive period, and optionally waits for and deserialises a reply from the peer.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   host          : host handshake / status interface (slave side)
//   line_drive_en : buffer drive enable (registered, only ever 1 in TX)
//   line_data_out : buffer drive value (registered, 1 when not driving)
//   line_data_in  : sampled line value (idle level 1 via external pull-up)
module bidir_line_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned BIT_CYCLES   = 1,
    parameter int unsigned RX_TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    bidir_line_ctrl_if.slave    host,
    output logic                line_drive_en,
    output logic                line_data_out,
    input  logic                line_data_in
);

    localparam int unsigned FRAME_W  = DATA_WIDTH + 2;
    // Down-count from the start-bit cycle to the middle of the first data bit.
    localparam int unsigned RX_FIRST = BIT_CYCLES + BIT_CYCLES / 2 - 1;
    localparam int unsigned MAX_AB   = (GUARD_CYCLES > RX_TIMEOUT) ? GUARD_CYCLES : RX_TIMEOUT;
    localparam int unsigned MAX_CD   = (RX_FIRST + 1 > BIT_CYCLES) ? RX_FIRST + 1 : BIT_CYCLES;
    localparam int unsigned CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W    = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD     = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RXFIRST_LOAD = CNT_W'(RX_FIRST);
    localparam logic [BIT_W-1:0] TX_LAST_BIT  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] RX_STOP_BIT  = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle, StTurnOn, StTx, StTurnOff, StRxWait, StRx, StRxGuard
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;      // down-counter, reloaded on every state entry
    logic [BIT_W-1:0]      bit_q, bit_d;      // bit index within the current frame
    logic [FRAME_W-1:0]    shift_q, shift_d;  // TX frame out of the MSB, RX bits into the LSB
    logic                  reply_q, reply_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_err_q, rx_err_d;
    logic                  rx_timeout_q, rx_timeout_d;
    logic                  drive_en_q, data_out_q;
    logic                  tx_ready, accept;

    assign tx_ready = (state_q == StIdle) && line_data_in && rst_n;
    assign accept   = host.tx_valid && tx_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        reply_d      = reply_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_err_d     = 1'b0;
        rx_timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A falling line means the peer started a frame; it beats a pending word.
                if (!line_data_in) begin
                    state_d = StRx;
                    cnt_d   = RXFIRST_LOAD;
                    bit_d   = '0;
                end else if (accept) begin
                    state_d = StTurnOn;
                    cnt_d   = GUARD_LOAD;
                    shift_d = {1'b0, host.tx_data, 1'b1};
                    reply_d = host.expect_reply;
                end
            end
            StTurnOn: begin
                if (cnt_q == '0) begin
                    state_d = StTx;
                    cnt_d   = BIT_LOAD;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StTx: begin
                if (cnt_q == '0) begin
                    if (bit_q == TX_LAST_BIT) begin
                        state_d = StTurnOff;
                        cnt_d   = GUARD_LOAD;
                    end else begin
                        cnt_d   = BIT_LOAD;
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {shift_q[FRAME_W-2:0], 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StTurnOff: begin
                if (cnt_q == '0) begin
                    if (reply_q) begin
                        state_d = StRxWait;
                        cnt_d   = TIMEOUT_LOAD;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRxWait: begin
                // Start bit takes priority over a timeout on the final counted cycle.
                if (!line_data_in) begin
                    state_d = StRx;
                    cnt_d   = RXFIRST_LOAD;
                    bit_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d      = StIdle;
                    rx_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRx: begin
                if (cnt_q == '0) begin
                    if (bit_q == RX_STOP_BIT) begin
                        if (line_data_in) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = shift_q[DATA_WIDTH-1:0];
                        end else begin
                            rx_err_d = 1'b1;
                        end
                        state_d = StRxGuard;
                        cnt_d   = GUARD_LOAD;
                    end else begin
                        shift_d = {shift_q[FRAME_W-2:0], line_data_in};
                        bit_d   = bit_q + BIT_W'(1);
                        cnt_d   = BIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRxGuard: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            reply_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 1'b0;
            rx_timeout_q <= 1'b0;
            drive_en_q   <= 1'b0;
            data_out_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            reply_q      <= reply_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_err_q     <= rx_err_d;
            rx_timeout_q <= rx_timeout_d;
            // Line outputs follow the next state so they line up with state_q.
            drive_en_q   <= (state_d == StTx);
            data_out_q   <= (state_d == StTx) ? shift_d[FRAME_W-1] : 1'b1;
        end
    end

    assign host.tx_ready   = tx_ready;
    assign host.rx_valid   = rx_valid_q;
    assign host.rx_data    = rx_data_q;
    assign host.rx_err     = rx_err_q;
    assign host.rx_timeout = rx_timeout_q;
    assign host.busy       = (state_q != StIdle);
    assign line_drive_en   = drive_en_q;
    assign line_data_out   = data_out_q;

endmodule

// File: tb/tb_bidir_line_ctrl.sv
// Self-checking bench for bidir_line_ctrl: u0 uses default parameters with a modelled peer on
// the shared line, u1 uses BIT_CYCLES=4 with its own reset for the mid-frame reset case.
module tb_bidir_line_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_n1;
    logic en0, out0, en1, out1;
    logic peer_en, peer_val;
    logic line0, line1;

    bidir_line_ctrl_if #(.DATA_WIDTH(8)) h0 ();
    bidir_line_ctrl_if #(.DATA_WIDTH(8)) h1 ();

    // Resolved line: whoever drives wins, otherwise the pull-up.
    assign line0 = en0 ? out0 : (peer_en ? peer_val : 1'b1);
    assign line1 = en1 ? out1 : 1'b1;

    bidir_line_ctrl #(
        .DATA_WIDTH(8), .GUARD_CYCLES(2), .BIT_CYCLES(1), .RX_TIMEOUT(64)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .host(h0),
        .line_drive_en(en0), .line_data_out(out0), .line_data_in(line0)
    );

    bidir_line_ctrl #(
        .DATA_WIDTH(8), .GUARD_CYCLES(2), .BIT_CYCLES(4), .RX_TIMEOUT(64)
    ) u1 (
        .clk(clk), .rst_n(rst_n1), .host(h1),
        .line_drive_en(en1), .line_data_out(out1), .line_data_in(line1)
    );

    int errors = 0;
    int checks = 0;
    int contention = 0;
    int nv = 0, ne = 0, nt = 0;

    always @(negedge clk) begin
        if ((en0 && peer_en) || $isunknown(line0)) contention <= contention + 1;
        if (h0.rx_valid)   nv <= nv + 1;
        if (h0.rx_err)     ne <= ne + 1;
        if (h0.rx_timeout) nt <= nt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send0(input logic [7:0] data, input logic reply);
        int n = 0;
        @(negedge clk);
        while (!h0.tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send0 ready", 32'(h0.tx_ready), 1);
        h0.tx_valid     = 1'b1;
        h0.tx_data      = data;
        h0.expect_reply = reply;
        @(posedge clk);
        #1 h0.tx_valid = 1'b0;
    endtask

    // Peer frame at BIT_CYCLES=1; start bit is driven on entry.
    task automatic peer_frame(input logic [7:0] data, input logic stop);
        peer_en  = 1'b1;
        peer_val = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 7; i >= 0; i--) begin
            peer_val = data[i];
            @(posedge clk);
            #1;
        end
        peer_val = stop;
        @(posedge clk);
        #1;
        peer_en  = 1'b0;
        peer_val = 1'b1;
    endtask

    typedef struct {
        logic tx_valid;
        logic exp_ready;
        logic exp_en;
        logic exp_out;
        logic exp_busy;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] seq;
        logic [9:0] f96;
        int sv, se, st, w;

        // Test 1 table: cycle 0 presents the word, accepted at the following edge.
        seq = 10'b0101001011;
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) vecs[3+i] = '{1'b0, 1'b0, 1'b1, seq[9-i], 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; rst_n1 = 1'b0;
        peer_en = 1'b0; peer_val = 1'b1;
        h0.tx_valid = 1'b0; h0.tx_data = 8'h00; h0.expect_reply = 1'b0;
        h1.tx_valid = 1'b0; h1.tx_data = 8'h00; h1.expect_reply = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst drive_en",   32'(en0), 0);
        check("rst data_out",   32'(out0), 1);
        check("rst rx_data",    32'(h0.rx_data), 0);
        check("rst rx_valid",   32'(h0.rx_valid), 0);
        check("rst rx_err",     32'(h0.rx_err), 0);
        check("rst rx_timeout", 32'(h0.rx_timeout), 0);
        check("rst tx_ready",   32'(h0.tx_ready), 0);
        check("rst busy",       32'(h0.busy), 0);
        rst_n = 1'b1; rst_n1 = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: A5 without reply, cycle by cycle
        h0.tx_data = 8'hA5;
        h0.expect_reply = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            h0.tx_valid = vecs[k].tx_valid;
            #1;
            check($sformatf("t1[%0d] tx_ready", k), 32'(h0.tx_ready), 32'(vecs[k].exp_ready));
            check($sformatf("t1[%0d] drive_en", k), 32'(en0), 32'(vecs[k].exp_en));
            check($sformatf("t1[%0d] data_out", k), 32'(out0), 32'(vecs[k].exp_out));
            check($sformatf("t1[%0d] busy", k), 32'(h0.busy), 32'(vecs[k].exp_busy));
        end
        h0.tx_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Test 2: reply 3C starting 3 cycles after RX_WAIT entry
        sv = nv; se = ne;
        send0(8'hA5, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        peer_frame(8'h3C, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("t2 rx_valid count", 32'(nv - sv), 1);
        check("t2 rx_err count",   32'(ne - se), 0);
        check("t2 rx_data",        32'(h0.rx_data), 32'h3C);
        check("t2 busy",           32'(h0.busy), 0);

        // Test 3: silent peer -> timeout 64 cycles after RX_WAIT entry
        sv = nv; st = nt;
        send0(8'hA5, 1'b1);
        repeat (77) @(posedge clk);
        @(negedge clk);
        check("t3 timeout early",  32'(h0.rx_timeout), 0);
        check("t3 busy before",    32'(h0.busy), 1);
        @(negedge clk);
        check("t3 timeout pulse",  32'(h0.rx_timeout), 1);
        check("t3 busy after",     32'(h0.busy), 0);
        @(negedge clk);
        check("t3 timeout width",  32'(h0.rx_timeout), 0);
        check("t3 tx_ready",       32'(h0.tx_ready), 1);
        check("t3 timeout count",  32'(nt - st), 1);
        check("t3 rx_valid count", 32'(nv - sv), 0);
        check("t3 rx_data kept",   32'(h0.rx_data), 32'h3C);

        // Test 4: unsolicited FF with bad stop bit
        sv = nv; se = ne;
        @(posedge clk);
        #1;
        peer_frame(8'hFF, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t4 rx_err count",   32'(ne - se), 1);
        check("t4 rx_valid count", 32'(nv - sv), 0);
        check("t4 rx_data kept",   32'(h0.rx_data), 32'h3C);
        check("t4 busy",           32'(h0.busy), 0);

        // Test 5: line falls in the same cycle a word is offered
        sv = nv;
        @(negedge clk);
        peer_en = 1'b1; peer_val = 1'b0;
        h0.tx_valid = 1'b1; h0.tx_data = 8'h5A; h0.expect_reply = 1'b0;
        #1;
        check("t5 tx_ready low", 32'(h0.tx_ready), 0);
        peer_frame(8'hC3, 1'b1);
        w = 0;
        @(negedge clk);
        while (!h0.tx_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("t5 guard wait",   32'(w), 2);
        check("t5 tx_ready",     32'(h0.tx_ready), 1);
        check("t5 rx_valid",     32'(nv - sv), 1);
        check("t5 rx_data",      32'(h0.rx_data), 32'hC3);
        @(posedge clk);
        #1 h0.tx_valid = 1'b0;
        @(negedge clk);
        check("t5 accepted busy", 32'(h0.busy), 1);
        check("t5 turn_on en",    32'(en0), 0);
        repeat (16) @(posedge clk);
        #1;
        check("t5 done busy",     32'(h0.busy), 0);

        // Test 6: BIT_CYCLES=4, reset mid-TX then a clean frame
        @(negedge clk);
        check("t6 ready", 32'(h1.tx_ready), 1);
        h1.tx_valid = 1'b1; h1.tx_data = 8'h96;
        @(posedge clk);
        #1 h1.tx_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("t6 in tx", 32'(en1), 1);
        #2 rst_n1 = 1'b0;
        #1;
        check("t6 rst drive_en", 32'(en1), 0);
        check("t6 rst data_out", 32'(out1), 1);
        check("t6 rst busy",     32'(h1.busy), 0);
        check("t6 rst tx_ready", 32'(h1.tx_ready), 0);
        repeat (2) @(negedge clk);
        rst_n1 = 1'b1;
        @(negedge clk);
        check("t6 post busy",     32'(h1.busy), 0);
        check("t6 post tx_ready", 32'(h1.tx_ready), 1);
        h1.tx_valid = 1'b1;
        @(posedge clk);
        #1 h1.tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        f96 = {1'b0, 8'h96, 1'b1};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check($sformatf("t6 bit cycle %0d", c), 32'({en1, out1}), 32'({1'b1, f96[9 - c/4]}));
        end
        @(negedge clk);
        check("t6 release", 32'({en1, out1}), 32'({1'b0, 1'b1}));

        repeat (4) @(negedge clk);
        check("contention", 32'(contention), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
